// File: rtl/me_wb_pipe.sv
// me_wb_pipe: MEM->WB pipeline stage with a valid/ready handshake.
// A main register (M) feeds write-back. With SKID=1 a second register (S)
// absorbs the one entry that can arrive while in_ready is still registered
// high. With SKID=0 the stage is a single entry with combinational in_ready.
// Also selects the write-back value and counts retired entries.
module me_wb_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int WBC_W  = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   rdata_m,
    input  logic [XLEN-1:0]   pc_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [WBC_W-1:0]  wb_ctrl_m,
    input  logic              we_reg_m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_result_w,
    output logic [XLEN-1:0]   rdata_w,
    output logic [XLEN-1:0]   pc_w,
    output logic [REG_AW-1:0] rd_w,
    output logic [WBC_W-1:0]  wb_ctrl_w,
    output logic              we_reg_w,
    output logic [XLEN-1:0]   wb_data_w,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rdata;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [WBC_W-1:0]  ctrl;
        logic              we;
    } entry_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, in_entry;
    logic   rdy_q;
    logic   accept, retire;
    logic   load_main_in, load_main_skid, load_skid;

    // Bundle the incoming payload; x0 is never a real write target, so its
    // write enable is dropped at capture time.
    always_comb begin
        in_entry       = '0;
        in_entry.alu   = alu_result_m;
        in_entry.rdata = rdata_m;
        in_entry.pc    = pc_m;
        in_entry.rd    = rd_m;
        in_entry.ctrl  = wb_ctrl_m;
        in_entry.we    = we_reg_m & (rd_m != '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush wins over everything and empties the stage.
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_FULL;
                ST_FULL: begin
                    if (accept && !retire)      state_nxt = ST_SKID;
                    else if (!accept && retire) state_nxt = ST_EMPTY;
                end
                ST_SKID:  if (retire) state_nxt = ST_FULL;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs and register load controls derived from the state.
    always_comb begin
        out_valid      = (state != ST_EMPTY);
        in_ready       = (SKID != 0) ? rdy_q : (!rst && (!out_valid || out_ready));
        accept         = in_valid & in_ready;
        retire         = out_valid & out_ready;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush_i) begin
            case (state)
                ST_EMPTY: load_main_in = accept;
                ST_FULL: begin
                    if (accept && retire) load_main_in = 1'b1;
                    else if (accept)      load_skid    = 1'b1;
                end
                ST_SKID:  load_main_skid = retire;
                default: ;
            endcase
        end
    end

    // Registered in_ready: low only while the skid register is occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= (state_nxt != ST_SKID);
        end
    end

    // Payload registers hold their contents unless explicitly loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    // Retire counter; a retire in a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign alu_result_w = main_q.alu;
    assign rdata_w      = main_q.rdata;
    assign pc_w         = main_q.pc;
    assign rd_w         = main_q.rd;
    assign wb_ctrl_w    = main_q.ctrl;
    assign we_reg_w     = main_q.we & out_valid;

    // Write-back value select from the registered payload.
    always_comb begin
        case (wb_ctrl_w)
            WBC_W'(0): wb_data_w = alu_result_w;
            WBC_W'(1): wb_data_w = rdata_w;
            WBC_W'(2): wb_data_w = pc_w + XLEN'(4);
            default:   wb_data_w = alu_result_w;
        endcase
    end

endmodule

// File: tb/tb_me_wb_pipe.sv
// tb_me_wb_pipe: directed bench for me_wb_pipe (SKID=1, 4-bit retire counter).
// A queue-based model tracks what WB should see; a compare process checks
// the DUT against it every cycle, and directed literal checks pin the model.
module tb_me_wb_pipe;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int WBC_W  = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_result_m, rdata_m, pc_m;
    logic [REG_AW-1:0] rd_m;
    logic [WBC_W-1:0]  wb_ctrl_m;
    logic              we_reg_m;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   alu_result_w, rdata_w, pc_w;
    logic [REG_AW-1:0] rd_w;
    logic [WBC_W-1:0]  wb_ctrl_w;
    logic              we_reg_w;
    logic [XLEN-1:0]   wb_data_w;
    logic [CNT_W-1:0]  retire_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  ctrl;
        logic        we;
    } ent_t;

    ent_t mq[$];
    bit   mrdy = 1'b0;
    int   mcnt = 0;

    me_wb_pipe #(
        .XLEN(XLEN), .REG_AW(REG_AW), .WBC_W(WBC_W), .SKID(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_m(alu_result_m), .rdata_m(rdata_m), .pc_m(pc_m),
        .rd_m(rd_m), .wb_ctrl_m(wb_ctrl_m), .we_reg_m(we_reg_m),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_w(alu_result_w), .rdata_w(rdata_w), .pc_w(pc_w),
        .rd_w(rd_w), .wb_ctrl_w(wb_ctrl_w), .we_reg_w(we_reg_w),
        .wb_data_w(wb_data_w), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two entries; in_ready is what the occupancy
    // allowed after the previous edge.
    always @(posedge clk or posedge rst) begin
        bit   acc, ret;
        ent_t e;
        if (rst) begin
            mq.delete();
            mrdy = 1'b0;
            mcnt = 0;
        end else begin
            acc = in_valid && mrdy;
            ret = (mq.size() > 0) && out_ready;
            if (ret) mcnt++;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (ret) void'(mq.pop_front());
                if (acc) begin
                    e.alu   = alu_result_m;
                    e.rdata = rdata_m;
                    e.pc    = pc_m;
                    e.rd    = rd_m;
                    e.ctrl  = wb_ctrl_m;
                    e.we    = we_reg_m && (rd_m != 5'd0);
                    mq.push_back(e);
                end
            end
            mrdy = (mq.size() < 2);
        end
    end

    // Compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
        ent_t        h;
        logic [31:0] exp_wb;
        checkOutput("out_valid", out_valid, mq.size() != 0);
        checkOutput("in_ready", in_ready, mrdy);
        checkOutput("retire_cnt", retire_cnt, mcnt & 15);
        if (mq.size() != 0) begin
            h = mq[0];
            case (h.ctrl)
                2'd1:    exp_wb = h.rdata;
                2'd2:    exp_wb = h.pc + 32'd4;
                default: exp_wb = h.alu;
            endcase
            checkOutput("rd_w", rd_w, h.rd);
            checkOutput("alu_result_w", alu_result_w, h.alu);
            checkOutput("rdata_w", rdata_w, h.rdata);
            checkOutput("pc_w", pc_w, h.pc);
            checkOutput("wb_ctrl_w", wb_ctrl_w, h.ctrl);
            checkOutput("we_reg_w", we_reg_w, h.we);
            checkOutput("wb_data_w", wb_data_w, exp_wb);
        end
    end

    // Drive one cycle of inputs, return just after the edge that sampled them.
    task automatic applyStimulus(input bit v, input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [31:0] pc,
                                 input logic [1:0] ctrl, input bit we, input bit ordy, input bit fl);
        in_valid     = v;
        rd_m         = rd;
        alu_result_m = alu;
        rdata_m      = rdata;
        pc_m         = pc;
        wb_ctrl_m    = ctrl;
        we_reg_m     = we;
        out_ready    = ordy;
        flush_i      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic pushEntry(input logic [4:0] rd, input bit ordy);
        applyStimulus(1'b1, rd, 32'hA000_0000 | 32'(rd), 32'hD000_0000 | 32'(rd),
                      32'h0000_1000 + 32'(rd) * 4, 2'd0, 1'b1, ordy, 1'b0);
    endtask

    task automatic idleCycle(input bit ordy, input bit fl);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, ordy, fl);
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 0; in_valid = 0; out_ready = 0;
        alu_result_m = 0; rdata_m = 0; pc_m = 0; rd_m = 0; wb_ctrl_m = 0; we_reg_m = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_retire_cnt", retire_cnt, 0);
        checkOutput("rst_alu_result_w", alu_result_w, 0);
        checkOutput("rst_wb_data_w", wb_data_w, 0);
        checkOutput("rst_we_reg_w", we_reg_w, 0);
        rst = 1'b0;
        idleCycle(1'b0, 1'b0);
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Streaming, back-to-back with WB always ready
        pushEntry(5'd1, 1'b1);
        checkOutput("stream_valid1", out_valid, 1);
        checkOutput("stream_rd1", rd_w, 1);
        pushEntry(5'd2, 1'b1);
        checkOutput("stream_rd2", rd_w, 2);
        pushEntry(5'd3, 1'b1);
        checkOutput("stream_rd3", rd_w, 3);
        pushEntry(5'd4, 1'b1);
        checkOutput("stream_rd4", rd_w, 4);
        idleCycle(1'b1, 1'b0);
        checkOutput("stream_drained", out_valid, 0);
        checkOutput("stream_cnt", retire_cnt, 4);

        // Back-pressure: A, B fill the stage, C is held until space opens
        pushEntry(5'd5, 1'b0);
        checkOutput("bp_ready_after_A", in_ready, 1);
        pushEntry(5'd6, 1'b0);
        checkOutput("bp_ready_after_B", in_ready, 0);
        checkOutput("bp_head_A", rd_w, 5);
        pushEntry(5'd7, 1'b0);
        checkOutput("bp_C_held", in_ready, 0);
        pushEntry(5'd7, 1'b1);
        checkOutput("bp_head_B", rd_w, 6);
        checkOutput("bp_ready_again", in_ready, 1);
        pushEntry(5'd7, 1'b1);
        checkOutput("bp_head_C", rd_w, 7);
        idleCycle(1'b1, 1'b0);
        checkOutput("bp_cnt", retire_cnt, 7);

        // Flush from the skid state with an incoming entry
        pushEntry(5'd8, 1'b0);
        pushEntry(5'd9, 1'b0);
        checkOutput("fl_skid", in_ready, 0);
        applyStimulus(1'b1, 5'd10, 32'h10, 32'h10, 32'h10, 2'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_out_valid", out_valid, 0);
        checkOutput("fl_in_ready", in_ready, 1);
        checkOutput("fl_cnt", retire_cnt, 7);
        pushEntry(5'd11, 1'b0);
        idleCycle(1'b1, 1'b1);
        checkOutput("fl_retire_counts", retire_cnt, 8);
        pushEntry(5'd12, 1'b1);
        checkOutput("fl_next_entry", rd_w, 12);
        idleCycle(1'b1, 1'b0);
        checkOutput("fl_cnt_after", retire_cnt, 9);

        // x0 write suppression and write-back select
        applyStimulus(1'b1, 5'd0, 32'h1234, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("x0_we", we_reg_w, 0);
        checkOutput("x0_wb_alu", wb_data_w, 32'h1234);
        applyStimulus(1'b1, 5'd3, 32'h55, 32'h0, 32'hFFFF_FFFC, 2'd2, 1'b1, 1'b1, 1'b0);
        checkOutput("pc4_wrap", wb_data_w, 32'h0);
        checkOutput("pc4_we", we_reg_w, 1);
        applyStimulus(1'b1, 5'd4, 32'h66, 32'h8000_0001, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0);
        checkOutput("sel_rdata", wb_data_w, 32'h8000_0001);
        applyStimulus(1'b1, 5'd7, 32'h77, 32'h99, 32'h0, 2'd3, 1'b0, 1'b1, 1'b0);
        checkOutput("sel_other", wb_data_w, 32'h77);
        checkOutput("sel_we_off", we_reg_w, 0);
        idleCycle(1'b1, 1'b0);
        checkOutput("sel_cnt", retire_cnt, 13);

        // Reset asserted mid-stream while in the skid state
        pushEntry(5'd1, 1'b0);
        pushEntry(5'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_cnt", retire_cnt, 0);
        idleCycle(1'b0, 1'b0);
        rst = 1'b0;
        idleCycle(1'b0, 1'b0);
        checkOutput("mid_rst_release_ready", in_ready, 1);
        checkOutput("mid_rst_release_valid", out_valid, 0);

        // Counter wrap: 17 retires on a 4-bit counter
        for (int i = 1; i <= 17; i++) begin
            pushEntry(5'(i), 1'b1);
        end
        idleCycle(1'b1, 1'b0);
        checkOutput("cnt_wrap", retire_cnt, 1);

        idleCycle(1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
